// File: rtl/atm_teclado_if.sv
// Keypad/status bundle between the user terminal and the ATM controller.
// master = atm_teclado (transmitting end), slave = keypad scanner + ATM side.
interface atm_teclado_if;
    logic        TARJETA_INSERTADA;
    logic        TECLA_VALIDA;
    logic [3:0]  TECLA;
    logic        PIN_INCORRECTO;
    logic        BLOQUEO;
    logic        BALANCE_ACTUALIZADO;
    logic        FONDOS_INSUFICIENTES;
    logic        TARJETA_RECIBIDA;
    logic [3:0]  DIGITO;
    logic        DIGITO_STB;
    logic        TIPO_TRANS;
    logic [31:0] MONTO;
    logic        MONTO_STB;
    logic        ERROR_TECLA;
    logic        TIMEOUT;

    modport master (
        input  TARJETA_INSERTADA, TECLA_VALIDA, TECLA,
        input  PIN_INCORRECTO, BLOQUEO,
        input  BALANCE_ACTUALIZADO, FONDOS_INSUFICIENTES,
        output TARJETA_RECIBIDA, DIGITO, DIGITO_STB,
        output TIPO_TRANS, MONTO, MONTO_STB,
        output ERROR_TECLA, TIMEOUT
    );

    modport slave (
        output TARJETA_INSERTADA, TECLA_VALIDA, TECLA,
        output PIN_INCORRECTO, BLOQUEO,
        output BALANCE_ACTUALIZADO, FONDOS_INSUFICIENTES,
        input  TARJETA_RECIBIDA, DIGITO, DIGITO_STB,
        input  TIPO_TRANS, MONTO, MONTO_STB,
        input  ERROR_TECLA, TIMEOUT
    );
endinterface

// File: rtl/atm_teclado.sv
// Keypad-to-ATM terminal controller: PIN, transaction type and amount entry.
// Optional inactivity timeout enabled with `define TECLADO_TIMEOUT_EN.
module atm_teclado #(
    parameter int N_DIGITOS_PIN     = 4,
    parameter int MAX_DIGITOS_MONTO = 9,
    parameter int CICLOS_TIMEOUT    = 1000
) (
    input  logic CLK,
    input  logic RESET,
    atm_teclado_if.master bus
);
    localparam int CW = $clog2(MAX_DIGITOS_MONTO + N_DIGITOS_PIN + 1);
    localparam logic [3:0] K_ENTER  = 4'hA;
    localparam logic [3:0] K_CANCEL = 4'hB;
    localparam logic [3:0] K_RETIRO = 4'hC;
    localparam logic [3:0] K_DEPOS  = 4'hD;

    typedef enum logic [2:0] {
        IDLE, PIN, SELECCION, MONTO_ENT, ESPERA, BLOQUEADO
    } estado_t;

    estado_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   acc_q, acc_d;
    logic          rec_q, rec_d;
    logic [3:0]    dig_q, dig_d;
    logic          dstb_q, dstb_d;
    logic          tipo_q, tipo_d;
    logic [31:0]   monto_q, monto_d;
    logic          mstb_q, mstb_d;
    logic          err_q, err_d;
    logic          to_q, to_d;
    logic          expira, espera_retiro;
    logic          tecla, es_dig;

    assign tecla  = bus.TECLA_VALIDA;
    assign es_dig = bus.TECLA <= 4'd9;

`ifdef TECLADO_TIMEOUT_EN
    localparam int TW = $clog2(CICLOS_TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          wait_q, wait_d;
    logic          activo;

    assign activo = state_q inside {PIN, SELECCION, MONTO_ENT};
    assign expira = activo && !tecla && (tmo_q == TW'(CICLOS_TIMEOUT - 1));
    assign espera_retiro = wait_q;

    always_comb begin
        tmo_d = tmo_q + 1'b1;
        if (!activo || tecla || state_d != state_q) tmo_d = '0;
        wait_d = bus.TARJETA_INSERTADA && (wait_q || to_d);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tmo_q  <= '0;
            wait_q <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            wait_q <= wait_d;
        end
    end
`else
    assign expira        = 1'b0;
    assign espera_retiro = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dig_d   = dig_q;
        dstb_d  = 1'b0;
        tipo_d  = tipo_q;
        monto_d = monto_q;
        mstb_d  = 1'b0;
        err_d   = 1'b0;
        to_d    = 1'b0;
        // Priority: removal > block > bad PIN > timeout/completion > key.
        if (!bus.TARJETA_INSERTADA) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (bus.BLOQUEO && state_q != IDLE) begin
            state_d = BLOQUEADO;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (bus.PIN_INCORRECTO &&
                     state_q inside {PIN, SELECCION}) begin
            state_d = PIN;
            cnt_d   = '0;
        end else if (expira) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            to_d    = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!espera_retiro) begin
                        state_d = PIN;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end
                end
                PIN: begin
                    if (tecla) begin
                        if (es_dig) begin
                            dig_d  = bus.TECLA;
                            dstb_d = 1'b1;
                            cnt_d  = cnt_q + 1'b1;
                            if (cnt_q == CW'(N_DIGITOS_PIN - 1)) begin
                                state_d = SELECCION;
                                cnt_d   = '0;
                            end
                        end else if (bus.TECLA == K_CANCEL) begin
                            cnt_d = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                SELECCION: begin
                    if (tecla) begin
                        if (bus.TECLA == K_RETIRO ||
                            bus.TECLA == K_DEPOS) begin
                            tipo_d  = bus.TECLA == K_RETIRO;
                            state_d = MONTO_ENT;
                            cnt_d   = '0;
                            acc_d   = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                MONTO_ENT: begin
                    if (tecla) begin
                        if (es_dig) begin
                            if (cnt_q < CW'(MAX_DIGITOS_MONTO)) begin
                                acc_d = acc_q * 32'd10 + {28'd0, bus.TECLA};
                                cnt_d = cnt_q + 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else if (bus.TECLA == K_ENTER) begin
                            if (cnt_q != '0) begin
                                monto_d = acc_q;
                                mstb_d  = 1'b1;
                                state_d = ESPERA;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else if (bus.TECLA == K_CANCEL) begin
                            acc_d = '0;
                            cnt_d = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ESPERA: begin
                    if (bus.BALANCE_ACTUALIZADO ||
                        bus.FONDOS_INSUFICIENTES) begin
                        state_d = IDLE;
                    end
                end
                BLOQUEADO: state_d = BLOQUEADO;
                default:   state_d = IDLE;
            endcase
        end
        rec_d = state_d inside {PIN, SELECCION, MONTO_ENT, ESPERA};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            rec_q   <= 1'b0;
            dig_q   <= '0;
            dstb_q  <= 1'b0;
            tipo_q  <= 1'b0;
            monto_q <= '0;
            mstb_q  <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rec_q   <= rec_d;
            dig_q   <= dig_d;
            dstb_q  <= dstb_d;
            tipo_q  <= tipo_d;
            monto_q <= monto_d;
            mstb_q  <= mstb_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    assign bus.TARJETA_RECIBIDA = rec_q;
    assign bus.DIGITO           = dig_q;
    assign bus.DIGITO_STB       = dstb_q;
    assign bus.TIPO_TRANS       = tipo_q;
    assign bus.MONTO            = monto_q;
    assign bus.MONTO_STB        = mstb_q;
    assign bus.ERROR_TECLA      = err_q;
    assign bus.TIMEOUT          = to_q;
endmodule

// File: tb/tb_atm_teclado.sv
// Directed bench for atm_teclado: PIN, withdrawal, deposit, reject paths.
// Build with +define+TECLADO_TIMEOUT_EN to exercise the timeout branch.
module tb_atm_teclado;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    atm_teclado_if bus ();

    atm_teclado #(
        .N_DIGITOS_PIN(4),
        .MAX_DIGITOS_MONTO(9),
        .CICLOS_TIMEOUT(20)
    ) dut (
        .CLK(clk),
        .RESET(rst_n),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        bus.TECLA_VALIDA = 1'b1;
        bus.TECLA = k;
        step();
        bus.TECLA_VALIDA = 1'b0;
        bus.TECLA = 4'h0;
    endtask

    task automatic pin1234();
        logic [3:0] d;
        for (int i = 1; i <= 4; i++) begin
            d = 4'(i);
            press(d);
            chk("pin_stb", 32'(bus.DIGITO_STB), 32'd1);
            chk("pin_dig", 32'(bus.DIGITO), 32'(i));
        end
    endtask

    task automatic insert();
        bus.TARJETA_INSERTADA = 1'b1;
        step();
    endtask

    task automatic remove();
        bus.TARJETA_INSERTADA = 1'b0;
        step();
        step();
    endtask

    initial begin
        int pulses;
        bus.TARJETA_INSERTADA = 1'b0;
        bus.TECLA_VALIDA = 1'b0;
        bus.TECLA = 4'h0;
        bus.PIN_INCORRECTO = 1'b0;
        bus.BLOQUEO = 1'b0;
        bus.BALANCE_ACTUALIZADO = 1'b0;
        bus.FONDOS_INSUFICIENTES = 1'b0;
        #2;
        chk("rst_rec", 32'(bus.TARJETA_RECIBIDA), 32'd0);
        chk("rst_monto", bus.MONTO, 32'd0);
        chk("rst_stb", 32'({bus.DIGITO_STB, bus.MONTO_STB, bus.ERROR_TECLA}), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Session 1: withdrawal of 250
        insert();
        chk("ins_rec", 32'(bus.TARJETA_RECIBIDA), 32'd1);
        pin1234();
        step();
        chk("stb_one", 32'(bus.DIGITO_STB), 32'd0);
        press(4'd7);
        chk("sel_dig_err", 32'(bus.ERROR_TECLA), 32'd1);
        chk("sel_dig_nostb", 32'(bus.DIGITO_STB), 32'd0);
        press(4'hC);
        chk("retiro_err", 32'(bus.ERROR_TECLA), 32'd0);
        chk("tipo_ret", 32'(bus.TIPO_TRANS), 32'd1);
        press(4'd2);
        press(4'd5);
        press(4'd0);
        chk("amt_nostb", 32'({bus.DIGITO_STB, bus.MONTO_STB}), 32'd0);
        press(4'hA);
        chk("m250_stb", 32'(bus.MONTO_STB), 32'd1);
        chk("m250", bus.MONTO, 32'h0000_00FA);
        step();
        chk("m250_stb1", 32'(bus.MONTO_STB), 32'd0);
        press(4'd3);
        chk("esp_ign", 32'({bus.DIGITO_STB, bus.ERROR_TECLA}), 32'd0);
        bus.BALANCE_ACTUALIZADO = 1'b1;
        step();
        bus.BALANCE_ACTUALIZADO = 1'b0;
        chk("bal_rec", 32'(bus.TARJETA_RECIBIDA), 32'd0);
        remove();

        // Session 2: deposit, empty ENTER, digit overflow
        insert();
        pin1234();
        press(4'hD);
        chk("tipo_dep", 32'(bus.TIPO_TRANS), 32'd0);
        press(4'hA);
        chk("enter0_err", 32'(bus.ERROR_TECLA), 32'd1);
        chk("enter0_nostb", 32'(bus.MONTO_STB), 32'd0);
        for (int i = 0; i < 10; i++) begin
            press(4'd9);
            chk("nine_err", 32'(bus.ERROR_TECLA), (i == 9) ? 32'd1 : 32'd0);
        end
        press(4'hA);
        chk("m999_stb", 32'(bus.MONTO_STB), 32'd1);
        chk("m999", bus.MONTO, 32'h3B9A_C9FF);
        bus.FONDOS_INSUFICIENTES = 1'b1;
        step();
        bus.FONDOS_INSUFICIENTES = 1'b0;
        chk("fondos_rec", 32'(bus.TARJETA_RECIBIDA), 32'd0);
        remove();

        // Session 3: PIN cancel, bad PIN, block
        insert();
        press(4'd1);
        press(4'd2);
        press(4'hB);
        chk("cancel_nostb", 32'({bus.DIGITO_STB, bus.ERROR_TECLA}), 32'd0);
        press(4'hE);
        chk("pin_bad_key", 32'(bus.ERROR_TECLA), 32'd1);
        pin1234();
        bus.PIN_INCORRECTO = 1'b1;
        step();
        bus.PIN_INCORRECTO = 1'b0;
        chk("badpin_rec", 32'(bus.TARJETA_RECIBIDA), 32'd1);
        for (int i = 5; i <= 8; i++) begin
            press(4'(i));
            chk("repin_stb", 32'(bus.DIGITO_STB), 32'd1);
            chk("repin_dig", 32'(bus.DIGITO), 32'(i));
        end
        press(4'd9);
        chk("repin_sel", 32'(bus.ERROR_TECLA), 32'd1);
        bus.BLOQUEO = 1'b1;
        step();
        bus.BLOQUEO = 1'b0;
        chk("blk_rec", 32'(bus.TARJETA_RECIBIDA), 32'd0);
        press(4'hC);
        press(4'd1);
        chk("blk_ign", 32'({bus.DIGITO_STB, bus.ERROR_TECLA}), 32'd0);
        chk("blk_stay", 32'(bus.TARJETA_RECIBIDA), 32'd0);
        remove();

        // Session 4: card removal, then reset, during amount entry
        insert();
        pin1234();
        press(4'hC);
        press(4'd4);
        press(4'd2);
        bus.TARJETA_INSERTADA = 1'b0;
        step();
        chk("rm_nostb", 32'(bus.MONTO_STB), 32'd0);
        chk("rm_monto", bus.MONTO, 32'h3B9A_C9FF);
        chk("rm_rec", 32'(bus.TARJETA_RECIBIDA), 32'd0);
        step();
        insert();
        pin1234();
        press(4'hC);
        press(4'd4);
        press(4'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_monto", bus.MONTO, 32'd0);
        chk("arst_rec", 32'(bus.TARJETA_RECIBIDA), 32'd0);
        chk("arst_tipo", 32'(bus.TIPO_TRANS), 32'd0);
        step();
        rst_n = 1'b1;
        bus.TECLA_VALIDA = 1'b1;
        bus.TECLA = 4'hA;
        step();
        bus.TECLA_VALIDA = 1'b0;
        chk("arst_noent", 32'(bus.MONTO_STB), 32'd0);
        step();
        chk("arst_pin", 32'(bus.TARJETA_RECIBIDA), 32'd1);

        // Inactivity in PIN
        pulses = 0;
`ifdef TECLADO_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.TIMEOUT) pulses++;
        end
        chk("tmo_pulses", 32'(pulses), 32'd1);
        chk("tmo_rec", 32'(bus.TARJETA_RECIBIDA), 32'd0);
`else
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.TIMEOUT) pulses++;
        end
        chk("tmo_none", 32'(pulses), 32'd0);
        chk("tmo_rec", 32'(bus.TARJETA_RECIBIDA), 32'd1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
